// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the encoder's FIFO entry type.
// Used by both the decode stage and this encoder.
package riscv_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPCODE_R_TYPE = 7'h33;
  localparam logic [6:0] OPCODE_I_TYPE = 7'h13;
  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } inst_entry_t;

  // True when v is representable as a signed value of the given bit width.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (bits - 1);
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field/handshake bundle between the instruction producer (master) and the
// encoder plus its memory-loader side (slave).
interface inst_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output pc_load, pc_load_val, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  pc_load, pc_load_val, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_count
  );

endinterface

// File: rtl/inst_fifo.sv
// Synchronous FIFO for encoded entries; head is read combinationally and
// reads as zero while empty.
module inst_fifo #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned WIDTH      = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + CntW'(1);
    end else if (pop_en && !push_en) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into instruction words, range-checks immediates,
// tags each word with a sequential address and queues it for the loader.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_encoder_if.slave bus
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

  logic [31:0] pc_q, pc_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [31:0] enc_inst, raw_inst, imm;
  logic        enc_ok;
  logic        accept, fifo_full, fifo_empty;
  inst_entry_t push_entry, head_entry;

  assign imm = bus.in_imm;

  always_comb begin
    raw_inst = NOP_INST;
    enc_ok   = 1'b0;
    case (bus.in_fmt)
      FMT_R: begin
        raw_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                    bus.in_opcode};
        enc_ok   = 1'b1;
      end
      FMT_I: begin
        raw_inst = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        enc_ok   = sext_fits(imm, 12);
      end
      FMT_S: begin
        raw_inst = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
        enc_ok   = sext_fits(imm, 12);
      end
      FMT_B: begin
        raw_inst = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1],
                    imm[11], bus.in_opcode};
        enc_ok   = sext_fits(imm, 13) && !imm[0];
      end
      FMT_U: begin
        raw_inst = {imm[31:12], bus.in_rd, bus.in_opcode};
        enc_ok   = (imm[11:0] == 12'h000);
      end
      FMT_J: begin
        raw_inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        enc_ok   = sext_fits(imm, 21) && !imm[0];
      end
      default: begin
        raw_inst = NOP_INST;
        enc_ok   = 1'b0;
      end
    endcase
    enc_inst = enc_ok ? raw_inst : NOP_INST;
  end

  // A load owns the cycle so the pushed address is never ambiguous.
  assign bus.in_ready = !fifo_full && !bus.pc_load;
  assign accept       = bus.in_valid && bus.in_ready;

  assign push_entry = '{inst: enc_inst, addr: pc_q, err: !enc_ok};

  always_comb begin
    pc_d        = pc_q;
    err_count_d = err_count_q;
    if (bus.pc_load) begin
      pc_d = {bus.pc_load_val[31:2], 2'b00};
    end else if (accept) begin
      pc_d = (pc_q == LAST_ADDR) ? BASE_ADDR : pc_q + 32'd4;
      if (!enc_ok && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= BASE_ADDR;
      err_count_q <= 8'h00;
    end else begin
      pc_q        <= pc_d;
      err_count_q <= err_count_d;
    end
  end

  inst_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      ($bits(inst_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (push_entry),
    .pop   (bus.out_ready),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_inst  = head_entry.inst;
  assign bus.out_addr  = head_entry.addr;
  assign bus.out_err   = head_entry.err;
  assign bus.err_count = err_count_q;

endmodule
